// File: rtl/rv_shift_arb.sv
// rv_shift_arb: round-robin sharing of one pipelined barrel shifter between
// two requesters, with tagged completion steering and credit-gated issue.

// Per-requester response FIFO; a push and a pop in the same cycle are legal at
// any occupancy, including full.
module rv_shift_arb_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned DW    = 32,
    parameter int unsigned CW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] dout_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= din_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_i) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign valid_o = (count != '0);
    assign dout_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

module rv_shift_arb #(
    parameter int unsigned LAT       = 1,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_d_i,
    input  logic [4:0]  req0_s_i,
    input  logic        req0_right_i,
    input  logic        req0_sig_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_d_i,
    input  logic [4:0]  req1_s_i,
    input  logic        req1_right_i,
    input  logic        req1_sig_i,

    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [31:0] rsp0_d_o,

    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp1_d_o,

    output logic        sh_ce_o,
    output logic [31:0] sh_d_o,
    output logic [4:0]  sh_s_o,
    output logic        sh_right_o,
    output logic        sh_sig_o,
    input  logic        sh_ce_i,
    input  logic [31:0] sh_d_i,

    output logic        err_o
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [CW-1:0]  cnt0, cnt1;
    logic [CW-1:0]  infl0, infl1;
    logic [1:0]     elig;
    logic [1:0]     grant;
    logic           gnt_id;
    logic           last;
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;
    logic           tail_v;
    logic           tail_id;
    logic           done0, done1;
    logic           push0, push1;
    logic           pop0, pop1;

    // Credit check: buffered plus in-flight results must leave room in the FIFO.
    always_comb begin
        elig    = '0;
        elig[0] = req0_valid_i && ((SW'(cnt0) + SW'(infl0)) < SW'(RSP_DEPTH));
        elig[1] = req1_valid_i && ((SW'(cnt1) + SW'(infl1)) < SW'(RSP_DEPTH));
    end

    // Round-robin grant; held off while reset is asserted so ready drops at once.
    always_comb begin
        grant = '0;
        if (rst_ni) begin
            if (elig == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
    end

    assign gnt_id       = grant[1];
    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];

    // Steer the granted operand straight to the shifter; zero when idle.
    always_comb begin
        sh_ce_o    = |grant;
        sh_d_o     = '0;
        sh_s_o     = '0;
        sh_right_o = 1'b0;
        sh_sig_o   = 1'b0;
        if (grant[0]) begin
            sh_d_o     = req0_d_i;
            sh_s_o     = req0_s_i;
            sh_right_o = req0_right_i;
            sh_sig_o   = req0_sig_i;
        end else if (grant[1]) begin
            sh_d_o     = req1_d_i;
            sh_s_o     = req1_s_i;
            sh_right_o = req1_right_i;
            sh_sig_o   = req1_sig_i;
        end
    end

    // Round-robin pointer: remembers the most recently granted port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last <= 1'b1;
        end else if (|grant) begin
            last <= gnt_id;
        end
    end

    // Tag pipe tracking {valid, id} alongside the shifter pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= sh_ce_o;
            tag_id[0] <= gnt_id;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign tail_v  = tag_v[LAT-1];
    assign tail_id = tag_id[LAT-1];

    // A valid tail tag always retires its credit; data is kept only with sh_ce_i.
    always_comb begin
        done0 = tail_v && !tail_id;
        done1 = tail_v && tail_id;
        push0 = done0 && sh_ce_i;
        push1 = done1 && sh_ce_i;
        pop0  = rsp0_valid_o && rsp0_ready_i;
        pop1  = rsp1_valid_o && rsp1_ready_i;
    end

    // Next in-flight count; a simultaneous issue and retire cancel out.
    function automatic logic [CW-1:0] infl_next(input logic [CW-1:0] cur,
                                                input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return cur + CW'(1);
            2'b01:   return cur - CW'(1);
            default: return cur;
        endcase
    endfunction

    // In-flight counters per requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            infl0 <= '0;
            infl1 <= '0;
        end else begin
            infl0 <= infl_next(infl0, grant[0], done0);
            infl1 <= infl_next(infl1, grant[1], done1);
        end
    end

    // Sticky error: shifter result with no tag, or tag with no shifter result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if ((sh_ce_i && !tail_v) || (tail_v && !sh_ce_i)) begin
            err_o <= 1'b1;
        end
    end

    rv_shift_arb_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (32),
        .CW    (CW)
    ) u_fifo0 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push0),
        .din_i   (sh_d_i),
        .pop_i   (pop0),
        .valid_o (rsp0_valid_o),
        .dout_o  (rsp0_d_o),
        .count_o (cnt0)
    );

    rv_shift_arb_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (32),
        .CW    (CW)
    ) u_fifo1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push1),
        .din_i   (sh_d_i),
        .pop_i   (pop1),
        .valid_o (rsp1_valid_o),
        .dout_o  (rsp1_d_o),
        .count_o (cnt1)
    );

endmodule
